// File: rtl/writeback_unit.sv
// writeback_unit
//   Merges ALU results and load data into a small circular queue, then
//   drains one entry per cycle into the register-file write port.
//   Load data is sign/zero-extended at enqueue time, so the queue holds
//   final write values only.
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   alu_valid/alu_rd/alu_result   ALU producer
//   load_valid/load_rd/load_data  load producer, raw little-endian data
//   load_size                     LB/LH/LW/LD/LBU/LHU/LWU, 111 illegal
//   in_ready                      both producers may present this cycle
//   write_en/addressC/writeBack   registered register-file write port
//   pending                       queue occupancy
//   size_err                      sticky, set when an illegal size is accepted
module writeback_unit #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DEPTH          = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_rd,
    input  logic [BUS_DATA_WIDTH-1:0]   alu_result,
    input  logic                        load_valid,
    input  logic [4:0]                  load_rd,
    input  logic [BUS_DATA_WIDTH-1:0]   load_data,
    input  logic [2:0]                  load_size,
    output logic                        in_ready,
    output logic                        write_en,
    output logic [4:0]                  addressC,
    output logic [BUS_DATA_WIDTH-1:0]   writeBack,
    output logic [$clog2(DEPTH):0]      pending,
    output logic                        size_err
);
    localparam int W  = BUS_DATA_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    function automatic logic [W-1:0] extend(input logic [W-1:0] d, input logic [2:0] sz);
        logic [W-1:0] v;
        case (sz)
            3'b000:  v = {{(W-8){d[7]}},   d[7:0]};
            3'b001:  v = {{(W-16){d[15]}}, d[15:0]};
            3'b010:  v = {{(W-32){d[31]}}, d[31:0]};
            3'b100:  v = {{(W-8){1'b0}},   d[7:0]};
            3'b101:  v = {{(W-16){1'b0}},  d[15:0]};
            3'b110:  v = {{(W-32){1'b0}},  d[31:0]};
            default: v = d;   // LD, and illegal 111 which behaves as LD
        endcase
        return v;
    endfunction

    logic [4:0]   r_q_rd   [DEPTH];
    logic [W-1:0] r_q_data [DEPTH];
    logic [PW-1:0] r_rptr, r_wptr;
    logic [CW-1:0] r_pending;
    logic          r_write_en;
    logic [4:0]    r_addr;
    logic [W-1:0]  r_wb;
    logic          r_size_err;

    logic          w_ready;
    logic          w_acc_ld, w_acc_alu;
    logic          w_push_ld, w_push_alu;
    logic          w_pop;
    logic [PW-1:0] w_wp_alu;
    logic [W-1:0]  w_ld_ext;

    assign w_ready    = (r_pending <= CW'(DEPTH - 2));
    assign w_acc_ld   = load_valid & w_ready;
    assign w_acc_alu  = alu_valid & w_ready;
    // writes to x0 are dropped at the door
    assign w_push_ld  = w_acc_ld  & (load_rd != 5'd0);
    assign w_push_alu = w_acc_alu & (alu_rd  != 5'd0);
    // pop decision uses pre-edge occupancy, so a push into an empty queue
    // is never forwarded straight to the output
    assign w_pop      = (r_pending != '0);
    // load goes first when both push; ALU lands one slot behind it
    assign w_wp_alu   = r_wptr + PW'(w_push_ld);
    assign w_ld_ext   = extend(load_data, load_size);

    // storage has no reset: occupancy and pointers define what is live
    always_ff @(posedge clk) begin
        if (w_push_ld) begin
            r_q_rd[r_wptr]   <= load_rd;
            r_q_data[r_wptr] <= w_ld_ext;
        end
        if (w_push_alu) begin
            r_q_rd[w_wp_alu]   <= alu_rd;
            r_q_data[w_wp_alu] <= alu_result;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_pending  <= '0;
            r_write_en <= 1'b0;
            r_addr     <= '0;
            r_wb       <= '0;
            r_size_err <= 1'b0;
        end else begin
            r_wptr    <= r_wptr + PW'(w_push_ld) + PW'(w_push_alu);
            r_pending <= r_pending + CW'(w_push_ld) + CW'(w_push_alu) - CW'(w_pop);
            r_write_en <= w_pop;
            if (w_pop) begin
                r_addr <= r_q_rd[r_rptr];
                r_wb   <= r_q_data[r_rptr];
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_acc_ld && load_size == 3'b111)
                r_size_err <= 1'b1;
        end
    end

    assign in_ready  = w_ready;
    assign write_en  = r_write_en;
    assign addressC  = r_addr;
    assign writeBack = r_wb;
    assign pending   = r_pending;
    assign size_err  = r_size_err;
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter BUS_DATA_WIDTH, default 64: the register data width.
REQ-002 The block SHALL have parameter DEPTH, default 4: the number of pending-write queue entries, a power of two and at least 4.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port alu_valid, input, 1 bit: an ALU result is presented.
REQ-006 The block SHALL have port alu_rd, input, 5 bits: the ALU destination register.
REQ-007 The block SHALL have port alu_result, input, BUS_DATA_WIDTH bits: the ALU result.
REQ-008 The block SHALL have port load_valid, input, 1 bit: load data is presented.
REQ-009 The block SHALL have port load_rd, input, 5 bits: the load destination register.
REQ-010 The block SHALL have port load_data, input, BUS_DATA_WIDTH bits: the raw little-endian load data, with the value in the low bits.
REQ-011 The block SHALL have port load_size, input, 3 bits, encoded 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 illegal.
REQ-012 The block SHALL have port in_ready, output, 1 bit: both producers may present this cycle.
REQ-013 The block SHALL have port write_en, output, 1 bit: the register-file write strobe.
REQ-014 The block SHALL have port addressC, output, 5 bits: the register-file write address.
REQ-015 The block SHALL have port writeBack, output, BUS_DATA_WIDTH bits: the register-file write data.
REQ-016 The block SHALL have port pending, output, $clog2(DEPTH)+1 bits: the current queue occupancy.
REQ-017 The block SHALL have port size_err, output, 1 bit: a sticky flag, set when an illegal load_size is accepted.

Function
REQ-018 in_ready SHALL be combinational: 1 when pending is at most DEPTH-2, else 0.
REQ-019 A producer's item SHALL be accepted on a rising edge only when its valid is 1 and in_ready is 1.
REQ-020 An accepted item with rd = 0 SHALL be discarded: it is not enqueued and never produces write_en.
REQ-021 When both producers are accepted on the same edge, the load item SHALL be enqueued ahead of the ALU item.
REQ-022 Load data SHALL be extended at enqueue time as follows:
- LB, LH and LW sign-extend bits 7, 15 and 31 respectively.
- LBU, LHU and LWU zero-extend the same fields.
- LD passes the data through unchanged.
REQ-023 load_size 111 SHALL be treated as LD and SHALL set size_err on the accepting edge.
REQ-024 The queue SHALL be circular; the read and write pointers wrap modulo DEPTH.
REQ-025 On each edge where the queue is non-empty, the head entry SHALL be popped into registered outputs: write_en=1, with addressC and writeBack taken from the entry.
REQ-026 On each edge where the queue is empty, write_en SHALL go to 0, and addressC and writeBack SHALL hold their last values.
REQ-027 The block SHALL issue at most one write per cycle.
REQ-028 Pop and push on the same edge SHALL be legal: pending' = pending + pushes - pop, where pushes is 0 to 2 and pop is 0 or 1.
REQ-029 Latency: an item accepted on edge E into an empty queue SHALL show write_en=1 in the cycle following edge E+1, which is two edges after presentation.
REQ-030 With the queue empty, a simultaneous push and pop on the same edge SHALL NOT bypass the queue; the item is seen only on the next pop.
REQ-031 Queue order SHALL be strict FIFO, so a later write to the same rd always follows an earlier one.
REQ-032 pending SHALL never exceed DEPTH; in_ready gating guarantees that two pushes always fit.

Reset
REQ-033 While reset_n=0, all of the following SHALL be forced to 0 immediately, independent of clk:
- write_en, addressC, writeBack, pending and size_err;
- both queue pointers.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries, with no write_en issued afterwards for them.
REQ-035 After reset_n deasserts, in_ready SHALL be 1 and the first accepting edge SHALL behave as on an empty queue.

Verification
REQ-036 Single ALU write: alu_valid=1, alu_rd=5, alu_result=0x1234 on edge E -> write_en=1, addressC=5, writeBack=0x1234 after E+1; write_en=0 after E+2.
REQ-037 Load extension: LB with data 0x80 -> writeBack=0xFFFFFFFFFFFFFF80; LBU with 0x80 -> 0x80; LW with 0x80000000 -> 0xFFFFFFFF80000000; load_size=111 -> data unchanged and size_err=1 until reset.
REQ-038 Simultaneous inputs: load rd=3 (0xAA) and ALU rd=3 (0xBB) accepted on the same edge -> writes on consecutive cycles, rd3=0xAA then rd3=0xBB; pending goes 0, 2, 1, 0.
REQ-039 x0 discard: alu_rd=0 with alu_valid=1 -> no write_en and pending stays 0.
REQ-040 Backpressure and wrap: drive both producers every cycle for 20 cycles, DEPTH=4 ->
- in_ready deasserts at pending 3 and 4;
- no item is lost or duplicated across pointer wrap;
- the output sequence matches the reference model.
REQ-041 Reset mid-burst: assert reset_n=0 with pending=3 -> write_en, pending and pointers are 0 without a clock edge, and no stale writes appear after release.
